// File: rtl/swd_target_responder_if.sv
// swd_target_responder_if: SWD pin, configuration and event bundle between host side and target model
interface swd_target_responder_if #(
  parameter int TURN_W = 2,
  parameter int WAIT_W = 4,
  parameter int BANK_W = 2
);
  logic                swclk_i;
  logic                swdio_i;
  logic                swdio_o;
  logic                swdio_oe;
  logic [TURN_W-1:0]   cfg_turn;
  logic [WAIT_W-1:0]   cfg_wait_cnt;
  logic                cfg_fault;
  logic                err_clr;
  logic                wr_valid;
  logic [4+BANK_W-1:0] wr_addr;
  logic [31:0]         wr_data;
  logic                txn_done;
  logic [2:0]          txn_ack;
  logic                hdr_err;
  logic                data_err;
  logic                line_reset;
  modport slave (
    input  swclk_i, swdio_i, cfg_turn, cfg_wait_cnt, cfg_fault, err_clr,
    output swdio_o, swdio_oe, wr_valid, wr_addr, wr_data, txn_done, txn_ack,
           hdr_err, data_err, line_reset
  );
  modport master (
    output swclk_i, swdio_i, cfg_turn, cfg_wait_cnt, cfg_fault, err_clr,
    input  swdio_o, swdio_oe, wr_valid, wr_addr, wr_data, txn_done, txn_ack,
           hdr_err, data_err, line_reset
  );
endinterface

// File: rtl/swd_target_responder.sv
// swd_target_responder: oversampling SWD target with WAIT/FAULT injection, line reset and banked DP/AP registers
module swd_target_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TURN_W      = 2,
  parameter int          WAIT_W      = 4,
  parameter int          BANK_W      = 2,
  parameter logic [31:0] IDCODE      = 32'h0BC1_1477
) (
  input logic                  clk,
  input logic                  resetn,
  swd_target_responder_if.slave bus
);
  localparam int IW = 3 + BANK_W;
  localparam logic [2:0] ACK_OK = 3'b001, ACK_WAIT = 3'b010, ACK_FAULT = 3'b100;
  typedef enum logic [3:0] {IDLE, HDR, TURN1, ACK, RDATA, RPAR, TURN2, WDATA, WPAR} state_t;
  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_ck_s, r_io_s;
  logic                  r_ck_d;
  logic [4:0]            r_cnt;
  logic [5:0]            r_hdr;
  logic [31:0]           r_sh;
  logic                  r_par;
  logic [2:0]            r_ack;
  logic [WAIT_W-1:0]     r_wctr;
  logic [BANK_W-1:0]     r_sel;
  logic [5:0]            r_ones;
  logic                  r_blk;
  logic                  r_o, r_oe;
  logic                  r_wr_valid, r_txn_done, r_lr, r_hdr_err, r_data_err;
  logic [4+BANK_W-1:0]   r_wr_addr;
  logic [31:0]           r_wr_data;
  logic [31:0]           r_rf [2**IW];
  logic                  w_ck, w_io, w_rise, w_fall, w_lr, w_hdr_ok, w_turn_end, w_dp0;
  logic [TURN_W-1:0]     w_turn;
  logic [IW-1:0]         w_idx;
  logic [31:0]           w_rdata;
  logic [2:0]            w_ack_next;
  assign w_ck       = r_ck_s[SYNC_STAGES-1];
  assign w_io       = r_io_s[SYNC_STAGES-1];
  assign w_rise     = w_ck & ~r_ck_d;
  assign w_fall     = ~w_ck & r_ck_d;
  assign w_turn     = bus.cfg_turn;
  assign w_turn_end = r_cnt == 5'(w_turn);
  // r_hdr holds {stop, parity, A3, A2, RnW, APnDP}; w_io is the park bit on the final header rise
  assign w_hdr_ok   = w_io && !r_hdr[5] && (r_hdr[4] == ^r_hdr[3:0]);
  assign w_idx      = {r_hdr[0], r_sel, r_hdr[3], r_hdr[2]};
  assign w_dp0      = !r_hdr[0] && r_hdr[3:2] == 2'b00;
  assign w_rdata    = w_dp0 ? IDCODE : r_rf[w_idx];
  assign w_ack_next = bus.cfg_fault ? ACK_FAULT : (r_wctr < bus.cfg_wait_cnt) ? ACK_WAIT : ACK_OK;
  // Our own driven bits never count toward a line reset
  assign w_lr       = w_rise && !r_oe && w_io && r_ones == 6'd49;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_ck_s     <= '0;
      r_io_s     <= '0;
      r_ck_d     <= 1'b0;
      r_cnt      <= '0;
      r_hdr      <= '0;
      r_sh       <= '0;
      r_par      <= 1'b0;
      r_ack      <= '0;
      r_wctr     <= '0;
      r_sel      <= '0;
      r_ones     <= '0;
      r_blk      <= 1'b0;
      r_o        <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_txn_done <= 1'b0;
      r_lr       <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_data_err <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < 2**IW; i++) r_rf[i] <= '0;
    end else begin
      r_ck_s     <= {r_ck_s[SYNC_STAGES-2:0], bus.swclk_i};
      r_io_s     <= {r_io_s[SYNC_STAGES-2:0], bus.swdio_i};
      r_ck_d     <= w_ck;
      r_wr_valid <= 1'b0;
      r_txn_done <= 1'b0;
      r_lr       <= 1'b0;
      if (bus.err_clr) begin
        r_hdr_err  <= 1'b0;
        r_data_err <= 1'b0;
      end
      if (w_rise) begin
        r_ones <= (r_oe || !w_io) ? 6'd0 : (r_ones == 6'd50) ? r_ones : r_ones + 6'd1;
        if (!w_io) r_blk <= 1'b0;
        if (w_lr) begin
          r_lr    <= 1'b1;
          r_blk   <= 1'b1;
          r_state <= IDLE;
          r_wctr  <= '0;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            IDLE: if (w_io && !r_blk) begin
              r_state <= HDR;
              r_cnt   <= '0;
            end
            HDR: if (r_cnt == 5'd6) begin
              r_cnt <= '0;
              if (w_hdr_ok) begin
                r_state <= TURN1;
                r_ack   <= w_ack_next;
                if (!bus.cfg_fault) r_wctr <= (r_wctr < bus.cfg_wait_cnt) ? r_wctr + WAIT_W'(1) : '0;
              end else begin
                r_hdr_err <= 1'b1;
                r_state   <= IDLE;
              end
            end else begin
              r_hdr <= {w_io, r_hdr[5:1]};
              r_cnt <= r_cnt + 5'd1;
            end
            TURN1: if (w_turn_end) begin
              r_state <= ACK;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + 5'd1;
            ACK: if (r_cnt == 5'd2) begin
              r_cnt <= '0;
              if (r_ack == ACK_OK && r_hdr[1]) begin
                r_state <= RDATA;
                r_sh    <= w_rdata;
                r_par   <= ^w_rdata;
              end else r_state <= TURN2;
            end else r_cnt <= r_cnt + 5'd1;
            RDATA: begin
              r_sh    <= {1'b0, r_sh[31:1]};
              r_cnt   <= r_cnt + 5'd1;
              r_state <= r_cnt == 5'd31 ? RPAR : RDATA;
            end
            RPAR: begin
              r_state <= TURN2;
              r_cnt   <= '0;
            end
            TURN2: if (w_turn_end) begin
              r_cnt <= '0;
              if (r_ack == ACK_OK && !r_hdr[1]) r_state <= WDATA;
              else begin
                r_state    <= IDLE;
                r_txn_done <= 1'b1;
              end
            end else r_cnt <= r_cnt + 5'd1;
            WDATA: begin
              r_sh    <= {w_io, r_sh[31:1]};
              r_cnt   <= r_cnt + 5'd1;
              r_state <= r_cnt == 5'd31 ? WPAR : WDATA;
            end
            WPAR: begin
              r_state    <= IDLE;
              r_txn_done <= 1'b1;
              if ((^r_sh) == w_io) begin
                r_wr_valid   <= 1'b1;
                r_wr_addr    <= (4+BANK_W)'(w_idx);
                r_wr_data    <= r_sh;
                r_rf[w_idx]  <= r_sh;
                if (w_dp0) begin
                  r_hdr_err  <= 1'b0;
                  r_data_err <= 1'b0;
                end
                if (!r_hdr[0] && r_hdr[3:2] == 2'b10) r_sel <= r_sh[4 +: BANK_W];
              end else r_data_err <= 1'b1;
            end
            default: r_state <= IDLE;
          endcase
        end
      end else if (w_fall) begin
        r_oe <= (r_state == ACK) || (r_state == RDATA) || (r_state == RPAR);
        r_o  <= (r_state == ACK) ? (r_cnt == 5'd0 ? r_ack[0] : r_cnt == 5'd1 ? r_ack[1] : r_ack[2]) :
                (r_state == RDATA) ? r_sh[0] : (r_state == RPAR) && r_par;
      end
    end
  end
  assign bus.swdio_o    = r_o;
  assign bus.swdio_oe   = r_oe;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.txn_done   = r_txn_done;
  assign bus.txn_ack    = r_ack;
  assign bus.hdr_err    = r_hdr_err;
  assign bus.data_err   = r_data_err;
  assign bus.line_reset = r_lr;
endmodule

// File: tb/tb_swd_target_responder.sv
// tb_swd_target_responder: SWD host driver with scoreboarded transaction, write and bus-bit checks
module tb_swd_target_responder;
  localparam int HALF = 8;
  localparam logic [2:0] OK = 3'b001, WT = 3'b010, FL = 3'b100;
  typedef struct { logic [2:0] ack; bit rd; logic [31:0] d; } txn_t;
  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  logic clk = 1'b0, resetn = 1'b0, host_oe = 1'b0, host_o = 1'b0;
  int n_vec = 0, n_miss = 0, exp_lr = 0, got_lr = 0, rel_run = 0;
  bit oe_seen = 1'b0;
  txn_t q_txn[$];
  wr_t  q_wr[$];
  bit   bits[$];
  int   runs[$];
  swd_target_responder_if bus ();
  swd_target_responder dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  assign bus.swdio_i = bus.swdio_oe ? bus.swdio_o : host_oe ? host_o : 1'b1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge bus.swclk_i) begin
    if (bus.swdio_oe) bits.push_back(bus.swdio_o);
    if (!bus.swdio_oe && !host_oe) rel_run++;
    else begin
      if (rel_run > 0) runs.push_back(rel_run);
      rel_run = 0;
    end
  end
  always @(negedge clk) begin
    if (bus.swdio_oe) oe_seen = 1'b1;
    if (bus.line_reset) got_lr++;
    if (bus.txn_done) begin
      if (q_txn.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL txn_done: unexpected, ack %b", bus.txn_ack);
      end else begin
        txn_t e;
        logic [31:0] d;
        e = q_txn.pop_front();
        chk("txn_ack", bus.txn_ack, e.ack);
        chk("bus_bits", bits.size(), e.rd ? 36 : 3);
        if (bits.size() == (e.rd ? 36 : 3)) begin
          chk("bus_ack", {bits[2], bits[1], bits[0]}, e.ack);
          if (e.rd) begin
            for (int i = 0; i < 32; i++) d[i] = bits[3+i];
            chk("rdata", d, e.d);
            chk("rpar", bits[35], ^e.d);
          end
        end
        bits.delete();
      end
    end
    if (bus.wr_valid) begin
      if (q_wr.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL wr_valid: unexpected, addr %h data %h", bus.wr_addr, bus.wr_data);
      end else begin
        wr_t w;
        w = q_wr.pop_front();
        chk("wr_addr", bus.wr_addr, w.a);
        chk("wr_data", bus.wr_data, w.d);
      end
    end
  end
  task automatic cyc(input bit drv, input bit v);
    host_oe = drv;
    host_o  = v;
    repeat (HALF) @(negedge clk);
    bus.swclk_i = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.swclk_i = 1'b0;
  endtask
  // flags: bit0 corrupt header parity, bit1 corrupt data parity, bit2 stop after 10 read data bits
  task automatic txn(input bit ap, input bit rnw, input bit [1:0] a, input logic [31:0] d,
                     input logic [2:0] ack, input logic [5:0] wa, input bit [2:0] flags);
    bit hb[8];
    int t;
    txn_t e;
    wr_t  w;
    t = int'(bus.cfg_turn) + 1;
    hb = '{1'b1, ap, rnw, a[0], a[1], ap ^ rnw ^ a[0] ^ a[1] ^ flags[0], 1'b0, 1'b1};
    if (!flags[0] && !flags[2]) begin
      e.ack = ack; e.rd = rnw && ack == OK; e.d = d;
      q_txn.push_back(e);
    end
    if (ack == OK && !rnw && !flags[1] && !flags[0]) begin
      w.a = wa; w.d = d;
      q_wr.push_back(w);
    end
    cyc(1, 0); cyc(1, 0);
    foreach (hb[i]) cyc(1, hb[i]);
    if (flags[0]) begin
      cyc(1, 0); cyc(1, 0);
      return;
    end
    repeat (t + 3) cyc(0, 0);
    if (ack == OK && rnw) begin
      if (flags[2]) begin
        repeat (10) cyc(0, 0);
        return;
      end
      repeat (33 + t) cyc(0, 0);
    end else begin
      repeat (t) cyc(0, 0);
      if (ack == OK) begin
        for (int i = 0; i < 32; i++) cyc(1, d[i]);
        cyc(1, (^d) ^ flags[1]);
      end
    end
    cyc(1, 0); cyc(1, 0);
  endtask
  initial begin
    bus.swclk_i = 1'b0; bus.cfg_turn = '0; bus.cfg_wait_cnt = '0; bus.cfg_fault = 1'b0; bus.err_clr = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_oe", bus.swdio_oe, 0);
    chk("rst_o", bus.swdio_o, 0);
    chk("rst_hdr_err", bus.hdr_err, 0);
    chk("rst_data_err", bus.data_err, 0);
    chk("rst_pulses", {bus.wr_valid, bus.txn_done, bus.line_reset}, 0);
    // line reset: the leading ones also look like malformed headers
    repeat (56) cyc(1, 1);
    exp_lr++;
    repeat (4) @(negedge clk);
    chk("line_reset_cnt", got_lr, exp_lr);
    chk("hdr_err_from_ones", bus.hdr_err, 1);
    bus.err_clr = 1'b1; @(negedge clk); bus.err_clr = 1'b0; @(negedge clk);
    chk("err_clr", bus.hdr_err, 0);
    txn(0, 1, 2'b00, 32'h0BC11477, OK, 6'h00, 3'b000);
    txn(1, 0, 2'b01, 32'hDEADBEEF, OK, 6'h11, 3'b000);
    bus.cfg_turn = 2'd3;
    runs.delete();
    txn(1, 1, 2'b01, 32'hDEADBEEF, OK, 6'h00, 3'b000);
    chk("turn_runs", runs.size(), 2);
    if (runs.size() == 2) begin
      chk("turn1_len", runs[0], 4);
      chk("turn2_len", runs[1], 4);
    end
    bus.cfg_turn = 2'd1;
    bus.cfg_wait_cnt = 4'd2;
    txn(1, 1, 2'b01, 32'h0, WT, 6'h00, 3'b000);
    txn(1, 1, 2'b01, 32'h0, WT, 6'h00, 3'b000);
    txn(1, 1, 2'b01, 32'hDEADBEEF, OK, 6'h00, 3'b000);
    bus.cfg_wait_cnt = 4'd0;
    bus.cfg_fault = 1'b1;
    txn(1, 0, 2'b01, 32'h00000055, FL, 6'h00, 3'b000);
    chk("oe_after_fault", bus.swdio_oe, 0);
    bus.cfg_fault = 1'b0;
    oe_seen = 1'b0;
    txn(0, 1, 2'b00, 32'h0, OK, 6'h00, 3'b001);
    repeat (4) @(negedge clk);
    chk("hdr_err_set", bus.hdr_err, 1);
    chk("hdr_err_no_oe", oe_seen, 0);
    txn(0, 0, 2'b00, 32'h0000001E, OK, 6'h00, 3'b000);
    chk("abort_clears", bus.hdr_err, 0);
    txn(1, 0, 2'b01, 32'h12345678, OK, 6'h00, 3'b010);
    chk("data_err_set", bus.data_err, 1);
    txn(1, 1, 2'b01, 32'hDEADBEEF, OK, 6'h00, 3'b000);
    txn(0, 0, 2'b10, 32'h00000010, OK, 6'h02, 3'b000);
    txn(1, 0, 2'b01, 32'hA5A5A5A5, OK, 6'h15, 3'b000);
    txn(1, 1, 2'b01, 32'hA5A5A5A5, OK, 6'h00, 3'b000);
    bus.cfg_turn = 2'd0;
    txn(1, 1, 2'b01, 32'h0, OK, 6'h00, 3'b100);
    repeat (4) @(negedge clk);
    chk("oe_mid_rdata", bus.swdio_oe, 1);
    resetn = 1'b0;
    #1;
    chk("oe_async_reset", bus.swdio_oe, 0);
    chk("data_err_reset", bus.data_err, 0);
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    bits.delete();
    repeat (2) @(negedge clk);
    txn(1, 1, 2'b01, 32'h0, OK, 6'h00, 3'b000);
    repeat (40) @(negedge clk);
    chk("txn_q_empty", q_txn.size(), 0);
    chk("wr_q_empty", q_wr.size(), 0);
    chk("line_reset_total", got_lr, exp_lr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
